ffsr_pulse_driver: RTL
======================

# ffsr_pulse_driver

Control-side counterpart of the FFSR pulse-encoding chain. It accepts a binary target position over a valid/ready handshake, decodes the chain's one-hot state vector, and issues single-cycle `inc`/`dec` commands to walk the pulse to the target. It then verifies the final chain state and reports completion and error status. It sits between binary-domain logic and an N-stage FFSR built from the pulse basic blocks.

## Interface
- `N`, 16, number of FFSR stages (min 2); stage i holds the pulse when value = i
- `W`, 5, target/value width; must satisfy 2^W >= N
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `tgt_valid`  in  1  target offered
- `tgt_ready`  out  1  driver idle, target can be accepted
- `tgt_value`  in  W  requested pulse position
- `ffsr_state`  in  N  current stage outputs of the chain, bit i = stage i
- `inc`  out  1  chain command: stage i <= stage i-1 (pulse moves up, value+1)
- `dec`  out  1  chain command: stage i <= stage i+1 (pulse moves down, value-1)
- `cur_value`  out  W  driver's tracked pulse position
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  valid with `done`: transaction failed
- `err_code`  out  2  valid with `done`: 01 invalid state, 10 range, 11 final mismatch

## Operation
- States: IDLE, LOAD, RUN, CHECK. Reset -> IDLE.
- IDLE: `tgt_ready`=1. On `tgt_valid && tgt_ready`, capture `tgt_value` -> LOAD.
- LOAD: decode `ffsr_state`. Zero bits or more than one bit set -> `done`=1, `err`=1, `err_code`=01, -> IDLE. Otherwise `cur_value` <= decoded index, -> RUN.
- RUN, per cycle:
  - `cur_value` < target: `inc`=1, `cur_value`+1.
  - `cur_value` > target: `dec`=1, `cur_value`-1.
  - Equal: no command, -> CHECK.
- `inc` and `dec` are never both 1.
- No `inc` is issued at `cur_value`=N-1 and no `dec` at 0; the pulse is never shifted off either end.
- CHECK: require `ffsr_state` == one-hot(`cur_value`). `done`=1 for one cycle; on mismatch `err`=1, `err_code`=11. -> IDLE.
- `inc`, `dec`, `tgt_ready`, `done`, `err` and `err_code` are decoded from registers only; there is no combinational path from inputs.
- `cur_value` holds between transactions.

## Timing
- Reset values: all outputs 0, including `tgt_ready` while `rst` is high; state IDLE; `cur_value`=0.
- `rst` asserted mid-transaction: `inc`/`dec` drop immediately and the transaction is abandoned with no `done`. The chain is expected to be reset to its init value by the same `rst`.
- Latency: accept edge -> `done` in cycle d+3, where d = |target - start|. This is 1 LOAD cycle, d+1 RUN cycles and 1 CHECK cycle.
- A command asserted in cycle k updates the chain at the end of cycle k. CHECK samples `ffsr_state` at least one edge after the last command.
- `tgt_ready` falls in the cycle after acceptance and returns in the cycle after `done`. Back-to-back transactions are spaced d+4 cycles minimum.
- A `tgt_value` change while `tgt_ready`=0 is ignored.

## Configuration
- `FFSR_DRV_SATURATE_EN` defined: a target >= N is clamped to N-1 and the transaction runs normally with no error.
- `FFSR_DRV_SATURATE_EN` undefined: a target >= N is accepted, but LOAD is skipped and no command is issued. `done`=1 with `err`=1, `err_code`=10, in the cycle after acceptance; `cur_value` is unchanged.

## Test plan
- N=16, W=5, chain at pos 3, target 9 -> `inc` high 6 consecutive cycles; `done` in cycle 9 after accept; `err`=0; `cur_value`=9; `ffsr_state`=0x0200.
- Chain at pos 12, target 0 -> 12 `dec` cycles; `done` at cycle 15; `ffsr_state`=0x0001.
- Target equal to current position (5) -> no `inc`/`dec`; `done` at cycle 3; `err`=0.
- `ffsr_state`=0x0011 at LOAD -> no commands; `done` with `err_code`=01 in cycle 2.
- Target 20: without the macro, `done`/`err_code`=10 next cycle with no commands. With `FFSR_DRV_SATURATE_EN`, from pos 10 there are 5 `inc` pulses and the transaction ends at pos 15.
- `rst` pulsed during RUN after 2 of 6 steps -> `inc`=0 immediately, no `done`; afterwards `tgt_ready`=1 and a new target from the chain's init position completes correctly.

Source files
------------

// File: rtl/ffsr_pulse_driver.sv
// ffsr_pulse_driver: walks the one-hot pulse of an N-stage FFSR chain to a
// binary target using single-cycle inc/dec commands, then verifies the chain.
// Optional feature macro: FFSR_DRV_SATURATE_EN (clamp out-of-range targets to
// N-1 instead of reporting a range error).
module ffsr_pulse_driver #(
  parameter int unsigned N = 16,
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tgt_valid_i,
  output logic         tgt_ready_o,
  input  logic [W-1:0] tgt_value_i,
  input  logic [N-1:0] ffsr_state_i,
  output logic         inc_o,
  output logic         dec_o,
  output logic [W-1:0] cur_value_o,
  output logic         done_o,
  output logic         err_o,
  output logic [1:0]   err_code_o
);

  localparam int unsigned CODE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_CHECK
  } state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      tgt_q, tgt_d;
  logic [W-1:0]      cur_q, cur_d;
  logic              inc_q, inc_d;
  logic              dec_q, dec_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CODE_W-1:0] code_q, code_d;

  logic [W-1:0]      oh_idx;
  logic              oh_any;
  logic              oh_multi;
  logic              tgt_oor;
  logic [N-1:0]      exp_state;

  // One-hot decode of the chain state: index of the set bit plus validity flags
  always_comb begin
    oh_idx   = '0;
    oh_any   = 1'b0;
    oh_multi = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (ffsr_state_i[i]) begin
        if (oh_any) oh_multi = 1'b1;
        oh_any = 1'b1;
        oh_idx = W'(i);
      end
    end
  end

  assign tgt_oor   = (32'(tgt_value_i) >= N);
  assign exp_state = N'(1) << cur_q;

  // State and output registers; reset abandons any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tgt_q   <= '0;
      cur_q   <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cur_q   <= cur_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  // Next-state logic; status is computed one cycle early so CHECK only presents it
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cur_d   = cur_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    code_d  = '0;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    ready_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (tgt_valid_i && ready_q) begin
          if (tgt_oor) begin
`ifdef FFSR_DRV_SATURATE_EN
            tgt_d   = W'(N - 1);
            state_d = ST_LOAD;
`else
            done_d  = 1'b1;
            err_d   = 1'b1;
            code_d  = 2'b10;
            state_d = ST_CHECK;
`endif
          end else begin
            tgt_d   = tgt_value_i;
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (!oh_any || oh_multi) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          code_d  = 2'b01;
          state_d = ST_CHECK;
        end else begin
          cur_d   = oh_idx;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cur_q < tgt_q) begin
          cur_d = cur_q + W'(1);
        end else if (cur_q > tgt_q) begin
          cur_d = cur_q - W'(1);
        end else begin
          // Chain has had at least one edge since the last command here
          done_d  = 1'b1;
          state_d = ST_CHECK;
          if (ffsr_state_i != exp_state) begin
            err_d  = 1'b1;
            code_d = 2'b11;
          end
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Commands for the next cycle follow the next tracked position
    if (state_d == ST_RUN) begin
      inc_d = (cur_d < tgt_d);
      dec_d = (cur_d > tgt_d);
    end
    ready_d = (state_d == ST_IDLE);
  end

  assign tgt_ready_o = ready_q;
  assign inc_o       = inc_q;
  assign dec_o       = dec_q;
  assign cur_value_o = cur_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign err_code_o  = code_q;

endmodule
